key_repeater: RTL and testbench
===============================

Name: key_repeater

Overview:
- Consumer end of the debounced button interface.
- Takes two clean, already-debounced button levels and converts each into one-cycle action pulses for the game logic (move/fire):
  - one pulse on press;
  - after a hold delay, periodic auto-repeat pulses;
  - one pulse on release.
- Sits between the button debouncer outputs and the tank control logic, in the clk_50m domain.

Parameters:
- DELAY, 25000000, cycles from the press pulse to the first repeat pulse (500 ms at 50 MHz); legal range 2 to 2^CW.
- PERIOD, 5000000, cycles between consecutive repeat pulses (100 ms at 50 MHz); legal range 2 to 2^CW.
- CW, 25, width of each per-channel cycle counter; must hold max(DELAY,PERIOD)-1.

Ports:
- clk_50m  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- level0  input  1  debounced level, channel 0 (1 = pressed); synchronous to clk_50m
- level1  input  1  debounced level, channel 1
- evt0  output  1  one-cycle pulse: press or repeat, channel 0
- evt1  output  1  one-cycle pulse: press or repeat, channel 1
- rel0  output  1  one-cycle pulse on release, channel 0
- rel1  output  1  one-cycle pulse on release, channel 1
- held0  output  1  high while channel 0 is in HOLD or REPEAT
- held1  output  1  high while channel 1 is in HOLD or REPEAT

Behaviour:
- Two identical, fully independent channels. Each has its own FSM, CW-bit counter cnt, and registered outputs.
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0;
  - evt, rel, held = 0 immediately;
  - asserting reset mid-hold aborts with no rel pulse.
- All outputs are registered. evt and rel are high for exactly one cycle per event.
- FSM states: IDLE, HOLD, REPEAT.
- IDLE: when level = 1 is sampled at posedge k:
  - state <= HOLD, cnt <= 0;
  - evt = 1 during cycle k..k+1 (latency 1).
- HOLD:
  - level = 1 and cnt != DELAY-1: cnt <= cnt+1.
  - level = 1 and cnt == DELAY-1: evt pulse, cnt <= 0, state <= REPEAT.
  - The first repeat pulse follows the press pulse by exactly DELAY cycles.
- REPEAT:
  - level = 1 and cnt != PERIOD-1: cnt <= cnt+1.
  - level = 1 and cnt == PERIOD-1: evt pulse, cnt <= 0.
  - Repeat pulses are spaced exactly PERIOD cycles apart.
- Release: in HOLD or REPEAT, level = 0 sampled:
  - rel pulse, state <= IDLE, cnt <= 0;
  - no evt in that cycle, even if cnt was at its terminal value (release wins).
- held = 1 exactly when state is HOLD or REPEAT, registered with the state.
- Re-press immediately after release (level 1,0,1 on consecutive posedges): rel pulse, then press pulse on the next cycle. A new hold always restarts the full DELAY.
- level already 1 when reset deasserts: a press pulse occurs on the first posedge after deassertion.
- Both channels may emit evt or rel in the same cycle; there is no arbitration.
- Counters never wrap. They clear at the terminal count, so overflow is unreachable given legal parameters.
- No combinational path from level to any output.

Test Plan:
- DELAY=4, PERIOD=3, level0 rises and is held for 20 cycles:
  - evt0 pulses at cycles 1, 5, 8, 11, 14, 17, 20 after the first high sample;
  - held0 = 1 from cycle 1;
  - after level0 falls: rel0 is one pulse, held0 = 0.
- Short tap, level0 high for 2 cycles: exactly one evt0 and one rel0, no repeat.
- Release on the terminal cycle: level0 drops exactly when cnt == DELAY-1 in HOLD → rel0 = 1, evt0 = 0 that cycle; then IDLE.
- Channels independent: level0 and level1 rise on the same cycle → evt0 and evt1 coincide. level1 rises 2 cycles later → its repeat pulses are offset by 2. Releasing one channel leaves the other's cadence unchanged.
- Reset mid-REPEAT: drive rst_n low asynchronously between edges → all outputs 0 immediately, no rel pulse. With level0 still high at deassertion → evt0 on the first posedge after, then the full DELAY before the first repeat.
- Re-press pattern level0 = 1,1,0,1: evt0, rel0, evt0 on consecutive event cycles. The second hold's first repeat comes DELAY cycles after the second press.

Source files
------------

// File: rtl/key_repeater.sv
// rtl/key_repeater.sv - press / auto-repeat / release pulse generator for two debounced buttons
//
// Purpose:
//   Turns each debounced button level into one-cycle action pulses:
//   one evt pulse on press, evt pulses every PERIOD cycles once the
//   button has been held for DELAY cycles, and one rel pulse on release.
//   The two channels are fully independent copies of key_repeater_chan.
//
// Ports (key_repeater):
//   clk_50m       in   system clock
//   rst_n         in   asynchronous active-low reset
//   level0/1      in   debounced button levels, 1 = pressed, synchronous to clk_50m
//   evt0/1        out  one-cycle pulse on press or repeat
//   rel0/1        out  one-cycle pulse on release
//   held0/1       out  high while the channel is in HOLD or REPEAT
//
// Ports (key_repeater_chan):
//   clk_i, rst_ni, level_i  clock, reset, debounced level
//   evt_o, rel_o, held_o    registered channel outputs

module key_repeater_chan #(
    parameter int DELAY  = 25000000,
    parameter int PERIOD = 5000000,
    parameter int CW     = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic evt_o,
    output logic rel_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Terminal counts; the counter clears on reaching them, so it never wraps.
    localparam logic [CW-1:0] DELAY_TC  = CW'(DELAY - 1);
    localparam logic [CW-1:0] PERIOD_TC = CW'(PERIOD - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc_d;
    logic          evt_q;
    logic          rel_q;
    logic          held_q;

    assign cnt_inc_d = cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            evt_q <= 1'b0;
            rel_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (level_i) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                        evt_q   <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Release is checked first so it wins over a terminal count.
                    if (!level_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rel_q   <= 1'b1;
                        held_q  <= 1'b0;
                    end else if (cnt_q == DELAY_TC) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                        evt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                REPEAT: begin
                    if (!level_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        rel_q   <= 1'b1;
                        held_q  <= 1'b0;
                    end else if (cnt_q == PERIOD_TC) begin
                        cnt_q <= '0;
                        evt_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign evt_o  = evt_q;
    assign rel_o  = rel_q;
    assign held_o = held_q;

endmodule

module key_repeater #(
    parameter int DELAY  = 25000000,
    parameter int PERIOD = 5000000,
    parameter int CW     = 25
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic level0,
    input  logic level1,
    output logic evt0,
    output logic evt1,
    output logic rel0,
    output logic rel1,
    output logic held0,
    output logic held1
);

    key_repeater_chan #(
        .DELAY  (DELAY),
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_chan0 (
        .clk_i   (clk_50m),
        .rst_ni  (rst_n),
        .level_i (level0),
        .evt_o   (evt0),
        .rel_o   (rel0),
        .held_o  (held0)
    );

    key_repeater_chan #(
        .DELAY  (DELAY),
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_chan1 (
        .clk_i   (clk_50m),
        .rst_ni  (rst_n),
        .level_i (level1),
        .evt_o   (evt1),
        .rel_o   (rel1),
        .held_o  (held1)
    );

endmodule

// File: tb/tb_key_repeater.sv
// tb/tb_key_repeater.sv - directed vector bench for key_repeater
module tb_key_repeater;

    localparam int DELAY  = 4;
    localparam int PERIOD = 3;
    localparam int CW     = 4;

    // Expected output word layout: {evt0, evt1, rel0, rel1, held0, held1}
    typedef struct {
        string      tag;
        logic       l0;
        logic       l1;
        logic [5:0] exp;
    } vec_t;

    logic clk_50m = 1'b0;
    logic rst_n;
    logic level0;
    logic level1;
    logic evt0, evt1, rel0, rel1, held0, held1;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t vecs[$];

    key_repeater #(
        .DELAY  (DELAY),
        .PERIOD (PERIOD),
        .CW     (CW)
    ) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .level0  (level0),
        .level1  (level1),
        .evt0    (evt0),
        .evt1    (evt1),
        .rel0    (rel0),
        .rel1    (rel1),
        .held0   (held0),
        .held1   (held1)
    );

    always #5 clk_50m = ~clk_50m;

    function automatic logic [5:0] outs();
        return {evt0, evt1, rel0, rel1, held0, held1};
    endfunction

    task automatic check(input string tag, input int idx, input logic [5:0] exp);
        logic [5:0] got;
        got = outs();
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: outputs {evt0,evt1,rel0,rel1,held0,held1} got %b expected %b",
                     tag, idx, got, exp);
        end
    endtask

    task automatic add(input string tag, input logic l0, input logic l1, input logic [5:0] exp);
        vec_t v;
        v.tag = tag;
        v.l0  = l0;
        v.l1  = l1;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step(input logic l0, input logic l1);
        @(negedge clk_50m);
        level0 = l0;
        level1 = l1;
        @(posedge clk_50m);
        #1;
    endtask

    initial begin
        // Long hold on channel 0: evt0 at 1,5,8,11,14,17,20, then release.
        for (int j = 1; j <= 20; j++) begin
            if (j == 1 || j == 5 || j == 8 || j == 11 || j == 14 || j == 17 || j == 20)
                add("hold20", 1'b1, 1'b0, 6'b100010);
            else
                add("hold20", 1'b1, 1'b0, 6'b000010);
        end
        add("hold20", 1'b0, 1'b0, 6'b001000);
        add("hold20", 1'b0, 1'b0, 6'b000000);

        // Short tap: one evt, one rel, no repeat.
        add("tap", 1'b1, 1'b0, 6'b100010);
        add("tap", 1'b1, 1'b0, 6'b000010);
        add("tap", 1'b0, 1'b0, 6'b001000);
        add("tap", 1'b0, 1'b0, 6'b000000);

        // Release exactly on the HOLD terminal count: rel wins over evt.
        add("rel_tc", 1'b1, 1'b0, 6'b100010);
        add("rel_tc", 1'b1, 1'b0, 6'b000010);
        add("rel_tc", 1'b1, 1'b0, 6'b000010);
        add("rel_tc", 1'b1, 1'b0, 6'b000010);
        add("rel_tc", 1'b0, 1'b0, 6'b001000);
        add("rel_tc", 1'b0, 1'b0, 6'b000000);

        // Simultaneous press and release on both channels.
        add("both", 1'b1, 1'b1, 6'b110011);
        add("both", 1'b1, 1'b1, 6'b000011);
        add("both", 1'b0, 1'b0, 6'b001100);
        add("both", 1'b0, 1'b0, 6'b000000);

        // Channel 1 starts 2 cycles later; releasing it leaves channel 0 cadence intact.
        add("offset", 1'b1, 1'b0, 6'b100010);
        add("offset", 1'b1, 1'b0, 6'b000010);
        add("offset", 1'b1, 1'b1, 6'b010011);
        add("offset", 1'b1, 1'b1, 6'b000011);
        add("offset", 1'b1, 1'b1, 6'b100011);
        add("offset", 1'b1, 1'b1, 6'b000011);
        add("offset", 1'b1, 1'b1, 6'b010011);
        add("offset", 1'b1, 1'b1, 6'b100011);
        add("offset", 1'b1, 1'b0, 6'b000110);
        add("offset", 1'b1, 1'b0, 6'b000010);
        add("offset", 1'b1, 1'b0, 6'b100010);
        add("offset", 1'b0, 1'b0, 6'b001000);
        add("offset", 1'b0, 1'b0, 6'b000000);

        // Re-press 1,1,0,1: evt, rel, evt; second hold restarts full DELAY.
        add("repress", 1'b1, 1'b0, 6'b100010);
        add("repress", 1'b1, 1'b0, 6'b000010);
        add("repress", 1'b0, 1'b0, 6'b001000);
        add("repress", 1'b1, 1'b0, 6'b100010);
        add("repress", 1'b1, 1'b0, 6'b000010);
        add("repress", 1'b1, 1'b0, 6'b000010);
        add("repress", 1'b1, 1'b0, 6'b000010);
        add("repress", 1'b1, 1'b0, 6'b100010);
        add("repress", 1'b0, 1'b0, 6'b001000);
        add("repress", 1'b0, 1'b0, 6'b000000);

        // Reset state.
        rst_n  = 1'b0;
        level0 = 1'b0;
        level1 = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        check("reset", 0, 6'b000000);
        @(negedge clk_50m);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].l0, vecs[i].l1);
            check(vecs[i].tag, i, vecs[i].exp);
        end

        // Asynchronous reset mid-REPEAT while evt pulses are high on both channels.
        for (int j = 1; j <= 5; j++) step(1'b1, 1'b1);
        check("pre_rst", 5, 6'b110011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 6'b000000);
        @(posedge clk_50m);
        #1;
        check("rst_norel", 1, 6'b000000);
        @(negedge clk_50m);
        level1 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk_50m);
        #1;
        check("post_rst", 1, 6'b100010);
        for (int j = 2; j <= 4; j++) begin
            step(1'b1, 1'b0);
            check("post_rst", j, 6'b000010);
        end
        step(1'b1, 1'b0);
        check("post_rst", 5, 6'b100010);
        step(1'b0, 1'b0);
        check("post_rst", 6, 6'b001000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
